// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the debounced switch logic unit.
package logic_unit_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_NAND = 3'd2,
        LU_NOR  = 3'd3,
        LU_XOR  = 3'd4,
        LU_XNOR = 3'd5,
        LU_MAJ  = 3'd6,
        LU_ZERO = 3'd7
    } lu_mode_t;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

    // Callers zero-extend to 32 bits, so unused upper bits never count.
    function automatic logic [5:0] masked_popcount(input logic [31:0] v,
                                                   input logic [31:0] m);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i] & m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Single-bit synchroniser plus debouncer: a new level is accepted only after it
// has been seen on DEBOUNCE_CYCLES+1 consecutive synchronised samples.
module switch_debouncer
    import logic_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50_I,
    input  logic RESET_I,
    input  logic raw,
    output logic stable,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  synced;
    db_state_t             state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  stable_n;

    assign synced = sync_q[SYNC_DEPTH-1];
    assign busy   = (state == DB_COUNTING);

    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            sync_q <= '0;
            state  <= DB_STABLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], raw};
            state  <= state_n;
            cnt    <= cnt_n;
            stable <= stable_n;
        end
    end

    // Any matching sample drops back to STABLE, so short glitches never land.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stable_n = stable;
        if (synced == stable) begin
            state_n = DB_STABLE;
            cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
            state_n  = DB_STABLE;
            cnt_n    = '0;
            stable_n = synced;
        end else begin
            state_n = DB_COUNTING;
            cnt_n   = cnt + CW'(1);
        end
    end

endmodule

// File: rtl/debounced_logic_unit.sv
// Debounced switch bank feeding a selectable masked boolean reduction, with
// registered result, edge pulses and a saturating change counter.
module debounced_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EVT_W           = 8
) (
    input  logic              CLOCK_50_I,
    input  logic              RESET_I,
    input  logic [NUM_SW-1:0] SWITCH_I,
    input  logic [NUM_SW-1:0] MASK_I,
    input  logic [2:0]        MODE_I,
    input  logic              CLEAR_I,
    output logic [NUM_SW-1:0] SW_STABLE_O,
    output logic              BUSY_O,
    output logic              RESULT_O,
    output logic              RESULT_RISE_O,
    output logic              RESULT_FALL_O,
    output logic [EVT_W-1:0]  EVENT_COUNT_O
);

    localparam logic [EVT_W-1:0] CNT_SAT = '1;

    logic [NUM_SW-1:0]                  busy_vec;
    logic [SYNC_DEPTH-1:0][NUM_SW-1:0]  mask_sync;
    logic [SYNC_DEPTH-1:0][2:0]         mode_sync;
    logic [SYNC_DEPTH-1:0]              vld_pipe;
    logic [NUM_SW-1:0]                  mask_s, op;
    lu_mode_t                           mode_s;
    logic [31:0]                        op_ext, mask_ext;
    logic [5:0]                         pop_op, pop_mask;
    logic                               func, first_done, evt;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .CLOCK_50_I (CLOCK_50_I),
            .RESET_I    (RESET_I),
            .raw        (SWITCH_I[g]),
            .stable     (SW_STABLE_O[g]),
            .busy       (busy_vec[g])
        );
    end

    assign BUSY_O = |busy_vec;
    assign mask_s = mask_sync[SYNC_DEPTH-1];
    assign mode_s = lu_mode_t'(mode_sync[SYNC_DEPTH-1]);
    assign op     = SW_STABLE_O & mask_s;

    always_comb begin
        op_ext                 = '0;
        mask_ext               = '0;
        op_ext[NUM_SW-1:0]     = op;
        mask_ext[NUM_SW-1:0]   = mask_s;
        pop_op                 = masked_popcount(op_ext, mask_ext);
        pop_mask               = masked_popcount(mask_ext, mask_ext);
    end

    // Unmasked bits are forced to 1 for AND so an empty mask reduces to 1.
    always_comb begin
        func = 1'b0;
        case (mode_s)
            LU_AND:  func = &(op | ~mask_s);
            LU_OR:   func = |op;
            LU_NAND: func = ~&(op | ~mask_s);
            LU_NOR:  func = ~|op;
            LU_XOR:  func = ^op;
            LU_XNOR: func = ~^op;
            LU_MAJ:  func = (pop_op > (pop_mask >> 1));
            default: func = 1'b0;
        endcase
    end

    assign evt = first_done & (func ^ RESULT_O);

    // The result only starts tracking once the mask/mode synchronisers hold
    // real samples; that first load is silent so power-up never counts.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            mask_sync     <= '0;
            mode_sync     <= '0;
            vld_pipe      <= '0;
            first_done    <= 1'b0;
            RESULT_O      <= 1'b0;
            RESULT_RISE_O <= 1'b0;
            RESULT_FALL_O <= 1'b0;
            EVENT_COUNT_O <= '0;
        end else begin
            mask_sync     <= {mask_sync[SYNC_DEPTH-2:0], MASK_I};
            mode_sync     <= {mode_sync[SYNC_DEPTH-2:0], MODE_I};
            vld_pipe      <= {vld_pipe[SYNC_DEPTH-2:0], 1'b1};
            RESULT_RISE_O <= evt & func;
            RESULT_FALL_O <= evt & ~func;
            if (vld_pipe[SYNC_DEPTH-1]) begin
                RESULT_O   <= func;
                first_done <= 1'b1;
            end
            if (CLEAR_I)
                EVENT_COUNT_O <= '0;
            else if (evt && EVENT_COUNT_O != CNT_SAT)
                EVENT_COUNT_O <= EVENT_COUNT_O + EVT_W'(1);
        end
    end

endmodule
